// File: rtl/trace_commit_serializer.sv
// Dual-lane commit capture FIFO feeding a one-record-per-pulse trace port.
// Optional TRACE_DROP_CNT_EN adds a saturating dropped-record counter.
module trace_commit_serializer #(
   parameter int DEPTH = 8
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        commit0_valid_i,
   input  logic [31:0] commit0_pc_i,
   input  logic [31:0] commit0_instr_i,
   input  logic [4:0]  commit0_rd_i,
   input  logic [31:0] commit0_rd_data_i,
   input  logic        commit0_is_load_i,
   input  logic        commit0_is_store_i,
   input  logic        commit0_is_float_i,
   input  logic [1:0]  commit0_mem_size_i,
   input  logic [31:0] commit0_mem_addr_i,
   input  logic [31:0] commit0_mem_data_i,
   input  logic [4:0]  commit0_fflags_i,
   input  logic        commit1_valid_i,
   input  logic [31:0] commit1_pc_i,
   input  logic [31:0] commit1_instr_i,
   input  logic [4:0]  commit1_rd_i,
   input  logic [31:0] commit1_rd_data_i,
   input  logic        commit1_is_load_i,
   input  logic        commit1_is_store_i,
   input  logic        commit1_is_float_i,
   input  logic [1:0]  commit1_mem_size_i,
   input  logic [31:0] commit1_mem_addr_i,
   input  logic [31:0] commit1_mem_data_i,
   input  logic [4:0]  commit1_fflags_i,
   output logic        ready_o,
   output logic        overflow_o,
`ifdef TRACE_DROP_CNT_EN
   output logic [15:0] drop_cnt_o,
`endif
   output logic        valid_o,
   output logic [31:0] pc_o,
   output logic [31:0] instr_o,
   output logic [31:0] reg_data_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_data_o,
   output logic [4:0]  reg_addr_o,
   output logic [1:0]  mem_size_o,
   output logic        is_load_o,
   output logic        is_store_o,
   output logic        is_float_o,
   output logic [31:0] fpu_flags_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [4:0]  rd;
      logic [31:0] rd_data;
      logic        is_load;
      logic        is_store;
      logic        is_float;
      logic [1:0]  mem_size;
      logic [31:0] mem_addr;
      logic [31:0] mem_data;
      logic [4:0]  fflags;
   } rec_t;

   typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

   rec_t          mem [DEPTH];
   rec_t          rec0, rec1, first, hold;
   state_t        state;
   logic [AW-1:0] wptr, rptr;
   logic [CW-1:0] count, free;
   logic [1:0]    nvalid, npush, ndrop;
   logic          pop, valid;

   assign rec0 = {commit0_pc_i, commit0_instr_i, commit0_rd_i,
                  commit0_rd_data_i, commit0_is_load_i,
                  commit0_is_store_i, commit0_is_float_i,
                  commit0_mem_size_i, commit0_mem_addr_i,
                  commit0_mem_data_i, commit0_fflags_i};
   assign rec1 = {commit1_pc_i, commit1_instr_i, commit1_rd_i,
                  commit1_rd_data_i, commit1_is_load_i,
                  commit1_is_store_i, commit1_is_float_i,
                  commit1_mem_size_i, commit1_mem_addr_i,
                  commit1_mem_data_i, commit1_fflags_i};

   // Free space is taken before this cycle's pop, so drops are lane-ordered.
   assign free   = CW'(DEPTH) - count;
   assign nvalid = {1'b0, commit0_valid_i} + {1'b0, commit1_valid_i};
   assign first  = commit0_valid_i ? rec0 : rec1;
   assign pop    = (state != PULSE) && (count != '0);
   assign ready_o = free >= CW'(2);

   always_comb begin
      npush = nvalid;
      if (free == '0)
         npush = 2'd0;
      else if (free == CW'(1) && nvalid == 2'd2)
         npush = 2'd1;
      ndrop = nvalid - npush;
   end

   always_ff @(posedge clk_i) begin
      if (npush != 2'd0)
         mem[wptr] <= first;
      if (npush == 2'd2)
         mem[wptr + AW'(1)] <= rec1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state      <= IDLE;
         wptr       <= '0;
         rptr       <= '0;
         count      <= '0;
         hold       <= '0;
         valid      <= 1'b0;
         overflow_o <= 1'b0;
      end else begin
         wptr  <= wptr + AW'(npush);
         count <= count + CW'(npush) - CW'(pop);
         if (ndrop != 2'd0)
            overflow_o <= 1'b1;
         if (pop) begin
            hold <= mem[rptr];
            rptr <= rptr + AW'(1);
         end
         unique case (state)
            IDLE, GAP: begin
               valid <= pop;
               state <= pop ? PULSE : IDLE;
            end
            PULSE: begin
               valid <= 1'b0;
               state <= GAP;
            end
            default: begin
               valid <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef TRACE_DROP_CNT_EN
   logic [16:0] drop_sum;
   assign drop_sum = {1'b0, drop_cnt_o} + 17'(ndrop);

   always_ff @(posedge clk_i) begin
      if (!rst_ni)
         drop_cnt_o <= '0;
      else
         drop_cnt_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end
`endif

   assign valid_o     = valid;
   assign pc_o        = hold.pc;
   assign instr_o     = hold.instr;
   assign reg_addr_o  = hold.rd;
   assign reg_data_o  = hold.rd_data;
   assign is_load_o   = hold.is_load;
   assign is_store_o  = hold.is_store;
   assign is_float_o  = hold.is_float;
   assign mem_size_o  = hold.mem_size;
   assign mem_addr_o  = hold.mem_addr;
   assign mem_data_o  = hold.mem_data;
   assign fpu_flags_o = {27'b0, hold.fflags};

endmodule

// File: tb/tb_trace_commit_serializer.sv
// Scoreboard bench for trace_commit_serializer: directed records,
// a monitor pops expected records on every valid_o pulse.
module tb_trace_commit_serializer;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [4:0]  rd;
      logic [31:0] rd_data;
      logic        is_load;
      logic        is_store;
      logic        is_float;
      logic [1:0]  mem_size;
      logic [31:0] mem_addr;
      logic [31:0] mem_data;
      logic [4:0]  fflags;
   } rec_t;

   logic clk = 1'b0;
   logic rst_ni = 1'b0;
   logic v0 = 1'b0, v1 = 1'b0;
   rec_t in0 = '0, in1 = '0;

   logic        ready, overflow, valid;
   logic [31:0] pc, instr, reg_data, mem_addr, mem_data, fpu_flags;
   logic [4:0]  reg_addr;
   logic [1:0]  mem_size;
   logic        is_load, is_store, is_float;
`ifdef TRACE_DROP_CNT_EN
   logic [15:0] drop_cnt;
`endif

   int   n_checks = 0;
   int   n_fail = 0;
   rec_t exp_q[$];
   logic prev_valid = 1'b0;

   always #5 clk = ~clk;

   trace_commit_serializer #(.DEPTH(8)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .commit0_valid_i(v0), .commit0_pc_i(in0.pc),
      .commit0_instr_i(in0.instr), .commit0_rd_i(in0.rd),
      .commit0_rd_data_i(in0.rd_data), .commit0_is_load_i(in0.is_load),
      .commit0_is_store_i(in0.is_store), .commit0_is_float_i(in0.is_float),
      .commit0_mem_size_i(in0.mem_size), .commit0_mem_addr_i(in0.mem_addr),
      .commit0_mem_data_i(in0.mem_data), .commit0_fflags_i(in0.fflags),
      .commit1_valid_i(v1), .commit1_pc_i(in1.pc),
      .commit1_instr_i(in1.instr), .commit1_rd_i(in1.rd),
      .commit1_rd_data_i(in1.rd_data), .commit1_is_load_i(in1.is_load),
      .commit1_is_store_i(in1.is_store), .commit1_is_float_i(in1.is_float),
      .commit1_mem_size_i(in1.mem_size), .commit1_mem_addr_i(in1.mem_addr),
      .commit1_mem_data_i(in1.mem_data), .commit1_fflags_i(in1.fflags),
      .ready_o(ready), .overflow_o(overflow),
`ifdef TRACE_DROP_CNT_EN
      .drop_cnt_o(drop_cnt),
`endif
      .valid_o(valid), .pc_o(pc), .instr_o(instr),
      .reg_data_o(reg_data), .mem_addr_o(mem_addr),
      .mem_data_o(mem_data), .reg_addr_o(reg_addr),
      .mem_size_o(mem_size), .is_load_o(is_load),
      .is_store_o(is_store), .is_float_o(is_float),
      .fpu_flags_o(fpu_flags)
   );

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic rec_t mk(input logic [31:0] p);
      rec_t r;
      r = '0;
      r.pc = p;
      r.instr = p ^ 32'h0000_0013;
      r.rd = p[6:2];
      r.rd_data = ~p;
      return r;
   endfunction

   // Monitor: every pulse must match the oldest expected record.
   always @(negedge clk) begin
      rec_t act, e;
      if (valid) begin
         chk("no_back_to_back", {63'b0, prev_valid}, 64'd0);
         act = {pc, instr, reg_addr, reg_data, is_load, is_store, is_float,
                mem_size, mem_addr, mem_data, fpu_flags[4:0]};
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse: got pc %h expected none", pc);
         end else begin
            e = exp_q.pop_front();
            if (act !== e || fpu_flags[31:5] !== 27'b0) begin
               n_fail++;
               $display("FAIL record: got %h expected %h", act, e);
            end
         end
      end
      prev_valid = valid;
   end

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         v0 = 1'b0;
         v1 = 1'b0;
      end
   endtask

   int acc[8] = '{2, 2, 2, 2, 2, 0, 1, 0};

   initial begin
      rec_t r;
      repeat (3) @(negedge clk);
      rst_ni = 1'b1;
      chk("rst_valid", {63'b0, valid}, 64'd0);
      chk("rst_overflow", {63'b0, overflow}, 64'd0);
      chk("rst_ready", {63'b0, ready}, 64'd1);
      chk("rst_pc", {32'b0, pc}, 64'd0);
      chk("rst_reg_data", {32'b0, reg_data}, 64'd0);

      // Single lane-0 record: pulse in the cycle after edge k+1.
      @(negedge clk);
      r = '0;
      r.pc = 32'h8000_0000;
      r.rd = 5'd5;
      r.rd_data = 32'h12;
      in0 = r;
      v0 = 1'b1;
      exp_q.push_back(r);
      @(negedge clk);
      v0 = 1'b0;
      chk("lat_k", {63'b0, valid}, 64'd0);
      @(negedge clk);
      chk("lat_k1", {63'b0, valid}, 64'd1);
      chk("lat_pc", {32'b0, pc_o_w()}, 64'h8000_0000);
      chk("lat_rd", {59'b0, reg_addr}, 64'd5);
      chk("lat_rd_data", {32'b0, reg_data}, 64'h12);
      @(negedge clk);
      chk("lat_k2", {63'b0, valid}, 64'd0);
      idle_cycles(3);

      // Both lanes: pulses at t and t+2 in lane order.
      in0 = mk(32'h100);
      in1 = mk(32'h104);
      v0 = 1'b1;
      v1 = 1'b1;
      exp_q.push_back(mk(32'h100));
      exp_q.push_back(mk(32'h104));
      idle_cycles(2);
      chk("dual_t", {63'b0, valid}, 64'd1);
      chk("dual_t_pc", {32'b0, pc}, 64'h100);
      @(negedge clk);
      chk("dual_t1", {63'b0, valid}, 64'd0);
      chk("dual_t1_hold", {32'b0, pc}, 64'h100);
      @(negedge clk);
      chk("dual_t2", {63'b0, valid}, 64'd1);
      chk("dual_t2_pc", {32'b0, pc}, 64'h104);
      idle_cycles(3);

      // Store presented on lane 1 only.
      r = mk(32'h200);
      r.is_store = 1'b1;
      r.mem_size = 2'b01;
      r.mem_addr = 32'h2000;
      r.mem_data = 32'hBEEF;
      in1 = r;
      v1 = 1'b1;
      exp_q.push_back(r);
      idle_cycles(2);
      chk("st_valid", {63'b0, valid}, 64'd1);
      chk("st_is_store", {63'b0, is_store}, 64'd1);
      chk("st_size", {62'b0, mem_size}, 64'd1);
      chk("st_data", {32'b0, mem_data}, 64'h0000_BEEF);
      chk("st_addr", {32'b0, mem_addr}, 64'h2000);
      idle_cycles(3);

      // Floating-point record with accrued flags.
      r = mk(32'h300);
      r.is_float = 1'b1;
      r.fflags = 5'b00101;
      in0 = r;
      v0 = 1'b1;
      exp_q.push_back(r);
      idle_cycles(2);
      chk("fp_valid", {63'b0, valid}, 64'd1);
      chk("fp_flags", {32'b0, fpu_flags}, 64'h5);
      chk("fp_is_float", {63'b0, is_float}, 64'd1);
      idle_cycles(4);

      // Sustained dual-lane input: 11 of 16 records fit.
      for (int c = 0; c < 8; c++) begin
         if (c > 0) @(negedge clk);
         if (c == 4) chk("fill_ready_hi", {63'b0, ready}, 64'd1);
         if (c == 5) chk("fill_ready_lo", {63'b0, ready}, 64'd0);
         if (c == 5) chk("fill_ovf_clear", {63'b0, overflow}, 64'd0);
         if (c == 6) chk("fill_ovf_set", {63'b0, overflow}, 64'd1);
         in0 = mk(32'h1000 + 32'(c * 8));
         in1 = mk(32'h1004 + 32'(c * 8));
         v0 = 1'b1;
         v1 = 1'b1;
         if (acc[c] >= 1) exp_q.push_back(in0);
         if (acc[c] == 2) exp_q.push_back(in1);
      end
      idle_cycles(1);
      chk("fill_ovf_sticky", {63'b0, overflow}, 64'd1);
`ifdef TRACE_DROP_CNT_EN
      chk("fill_drop_cnt", {48'b0, drop_cnt}, 64'd5);
`endif
      idle_cycles(30);
      chk("fill_drained", 64'(exp_q.size()), 64'd0);
      chk("drain_ovf_sticky", {63'b0, overflow}, 64'd1);

      // Reset with 4 records buffered while a pulse is on the wire.
      for (int c = 0; c < 3; c++) begin
         if (c > 0) @(negedge clk);
         in0 = mk(32'h3000 + 32'(c * 8));
         in1 = mk(32'h3004 + 32'(c * 8));
         v0 = 1'b1;
         v1 = 1'b1;
         if (c == 0) exp_q.push_back(in0);
         if (c == 0) exp_q.push_back(in1);
      end
      idle_cycles(2);
      chk("pre_rst_pulse", {63'b0, valid}, 64'd1);
      chk("pre_rst_pc", {32'b0, pc}, 64'h3004);
      rst_ni = 1'b0;
      @(negedge clk);
      rst_ni = 1'b1;
      chk("mid_rst_valid", {63'b0, valid}, 64'd0);
      chk("mid_rst_overflow", {63'b0, overflow}, 64'd0);
      chk("mid_rst_ready", {63'b0, ready}, 64'd1);
      chk("mid_rst_pc", {32'b0, pc}, 64'd0);
`ifdef TRACE_DROP_CNT_EN
      chk("mid_rst_drop_cnt", {48'b0, drop_cnt}, 64'd0);
`endif
      idle_cycles(20);
      chk("post_rst_quiet", {63'b0, valid}, 64'd0);
      chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   function automatic logic [31:0] pc_o_w();
      return pc;
   endfunction

endmodule

// File: doc/trace_commit_serializer.md
# trace_commit_serializer

Testbench-side block that sits directly upstream of the execution trace writer. It captures up to two in-order retirement records per cycle from the core's commit stage and buffers them in a FIFO. It replays them one at a time as a single-cycle `valid_o` pulse with a mandatory low cycle between records, because the trace writer triggers on each rising edge of `valid`. It also reports overflow when the commit stream outruns the buffer.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥ 4.
- `clk_i` in 1: clock.
- `rst_ni` in 1: synchronous, active-low reset.
- `commitN_valid_i` in 1 (N = 0,1): lane N retires an instruction this cycle; lane 0 is older.
- `commitN_pc_i` in 32 (N = 0,1): retired PC.
- `commitN_instr_i` in 32 (N = 0,1): instruction word.
- `commitN_rd_i` in 5 (N = 0,1): destination register index.
- `commitN_rd_data_i` in 32 (N = 0,1): destination write value.
- `commitN_is_load_i` / `_is_store_i` / `_is_float_i` in 1 (N = 0,1): record class flags.
- `commitN_mem_size_i` in 2 (N = 0,1): 00 byte, 01 half, 1x word.
- `commitN_mem_addr_i` / `_mem_data_i` in 32 (N = 0,1): memory address / store data.
- `commitN_fflags_i` in 5 (N = 0,1): accrued FP exception flags.
- `ready_o` out 1: at least 2 free FIFO entries.
- `overflow_o` out 1: sticky; a record was dropped.
- `valid_o` out 1: one-cycle record pulse to the trace writer.
- `pc_o`, `instr_o`, `reg_data_o`, `mem_addr_o`, `mem_data_o` out 32 each: current record.
- `reg_addr_o` out 5, `mem_size_o` out 2, `is_load_o`, `is_store_o`, `is_float_o` out 1 each.
- `fpu_flags_o` out 32: `{27'b0, fflags}`.

## Operation
- Push: each cycle, enqueue valid lanes in order (lane 0 first).
  - Lane 1 valid with lane 0 invalid enqueues as a single record.
  - Free-space check is per record, in lane order. A record that finds the FIFO full is dropped and sets `overflow_o`.
  - If lane 0 drops, lane 1 also drops.
  - `ready_o` is advisory only; no push is blocked.
- Occupancy counter is `clog2(DEPTH)+1` bits. Pointers wrap modulo `DEPTH`.
- Simultaneous push of 2 and pop of 1 is legal. Free space for this cycle's push is evaluated before this cycle's pop.
- Output FSM states: IDLE, PULSE, GAP.
  - IDLE: if FIFO non-empty, load head into output regs, pop, go to PULSE. Otherwise stay.
  - PULSE: `valid_o`=1; go to GAP unconditionally.
  - GAP: `valid_o`=0, data held. If non-empty, load and pop the next record, go to PULSE; else go to IDLE.
- Output data regs change only on a load. They stay stable through PULSE and GAP.
- `overflow_o` clears only on reset.

## Timing
- Reset (`rst_ni`=0 at a clock edge):
  - FSM to IDLE; FIFO emptied.
  - `valid_o`, `overflow_o`, and all data outputs become 0.
  - `ready_o`=1 from the first cycle after reset.
- Reset mid-operation discards all buffered records and any pending pulse.
- Latency: a record pushed at edge k (FIFO was empty, FSM in IDLE) gives `valid_o`=1 during the cycle after edge k+1.
- Throughput: 1 record per 2 cycles. `valid_o` is never high in two consecutive cycles.
- A sustained 2-records/cycle input fills `DEPTH` entries after about `DEPTH`/1.5 cycles. Drops follow.
- `ready_o` is combinational from occupancy: `DEPTH - count ≥ 2`.

## Configuration
- `TRACE_DROP_CNT_EN` defined:
  - Adds output port `drop_cnt_o` (16 bits), reset 0.
  - Increments by the number of records dropped each cycle (0, 1 or 2) and saturates at 16'hFFFF.
- `TRACE_DROP_CNT_EN` undefined: the port and counter are absent; only `overflow_o` reports drops.

## Test plan
- Reset, then a lane-0 record with pc=0x80000000, rd=5, rd_data=0x12 → `valid_o` high exactly 1 cycle, 2 edges after push; `pc_o`=0x80000000, `reg_addr_o`=5, `reg_data_o`=0x12.
- Both lanes valid (pc 0x100, 0x104) → pulses at cycles t and t+2; order is 0x100 then 0x104; `valid_o` low at t+1.
- Store via lane 1 only, `mem_size`=01, addr=0x2000, data=0xBEEF → single pulse, `is_store_o`=1, `mem_size_o`=01, `mem_data_o`=0x0000BEEF.
- FP record with fflags=5'b00101 → `fpu_flags_o`=0x00000005, `is_float_o`=1.
- DEPTH=8, both lanes valid for 8 consecutive cycles:
  - `ready_o` falls once occupancy exceeds 6.
  - `overflow_o` sets on the first drop.
  - With `TRACE_DROP_CNT_EN`, `drop_cnt_o` equals 16 minus the accepted count.
  - Accepted records emerge in order, with no duplicates.
- Assert `rst_ni`=0 while 4 records are buffered and FSM is in PULSE → next cycle `valid_o`=0, FIFO empty, `overflow_o`=0; no further pulses occur without new input.
